// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write controller.
package lcd_pkg;

    // StInit is reachable only when LCD_INIT_SEQ_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StWait,
        StInit
    } lcd_state_e;

    // Bit positions within the 32-bit LCD word.
    localparam int unsigned ON_BIT   = 31;
    localparam int unsigned RS_BIT   = 10;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Power-up sequence: function set, display on, clear, entry mode (index 0 first).
    localparam int unsigned INIT_LEN = 4;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d,
                                         input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Clear and home (0x03 also decodes as home) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that stops at zero; used for every state duration.
module lcd_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_value,
    output logic             o_done
);

    logic [WIDTH-1:0] cnt_q;

    // Load on state entry, otherwise count down and hold at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign o_value = cnt_q;
    assign o_done  = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD bus writer: setup, EN pulse, hold, execution wait per word.
// Define LCD_INIT_SEQ_EN to run the built-in power-up command sequence after reset.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned EN_HIGH_CYC = 12,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned EXEC_CYC    = 2000,
    parameter int unsigned CLEAR_CYC   = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_valid,
    input  logic [31:0] i_lcd_word,
    output logic        o_wr_ready,
    output logic        o_busy,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data
);

    localparam int unsigned CNT_W =
        $clog2(max5(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC, EXEC_CYC, CLEAR_CYC) + 1);

    lcd_state_e       state_q, state_d;
    logic             on_q, on_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             ready_q, en_q, busy_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;
    logic             accept;
    logic             unused_bits;

    assign unused_bits = ^{i_lcd_word[30:11], i_lcd_word[9:8], tmr_value};
    assign accept      = i_wr_valid && ready_q;

`ifdef LCD_INIT_SEQ_EN
    logic       init_act_q, init_act_d;
    logic [1:0] init_idx_q, init_idx_d;
    localparam lcd_state_e RESET_STATE = StInit;
`else
    localparam lcd_state_e RESET_STATE = StIdle;
`endif

    lcd_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (tmr_load),
        .i_load_val(tmr_val),
        .o_value   (tmr_value),
        .o_done    (tmr_done)
    );

    // Next-state, latched bus values and timer load for each state entry.
    always_comb begin
        state_d  = state_q;
        on_d     = on_q;
        rs_d     = rs_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef LCD_INIT_SEQ_EN
        init_act_d = init_act_q;
        init_idx_d = init_idx_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    on_d = i_lcd_word[ON_BIT];
                    if (i_lcd_word[ON_BIT]) begin
                        rs_d     = i_lcd_word[RS_BIT];
                        data_d   = i_lcd_word[DATA_MSB:DATA_LSB];
                        state_d  = StSetup;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d  = StPulse;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(EN_HIGH_CYC - 1);
                end
            end
            StPulse: begin
                if (tmr_done) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC - 1);
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d  = StWait;
                    tmr_load = 1'b1;
                    tmr_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(CLEAR_CYC - 1)
                                                         : CNT_W'(EXEC_CYC - 1);
                end
            end
            StWait: begin
                if (tmr_done) begin
                    state_d = StIdle;
`ifdef LCD_INIT_SEQ_EN
                    if (init_act_q) begin
                        if (init_idx_q == 2'(INIT_LEN - 1)) begin
                            init_act_d = 1'b0;
                        end else begin
                            init_idx_d = init_idx_q + 1'b1;
                            state_d    = StInit;
                        end
                    end
`endif
                end
            end
`ifdef LCD_INIT_SEQ_EN
            StInit: begin
                on_d     = 1'b1;
                rs_d     = 1'b0;
                data_d   = INIT_ROM[init_idx_q];
                state_d  = StSetup;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(SETUP_CYC - 1);
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; outputs follow state_d so they change with the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RESET_STATE;
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ready_q <= (state_d == StIdle);
            en_q    <= (state_d == StPulse);
            busy_q  <= (state_d != StIdle);
        end
    end

`ifdef LCD_INIT_SEQ_EN
    // Power-up sequence progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            init_act_q <= 1'b1;
            init_idx_q <= 2'd0;
        end else begin
            init_act_q <= init_act_d;
            init_idx_q <= init_idx_d;
        end
    end
`endif

    assign o_wr_ready = ready_q;
    assign o_busy     = busy_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with default timing parameters.
module tb_lcd_ctrl;

    localparam int SETUP = 4;
    localparam int ENH   = 12;
    localparam int HOLD  = 2;
    localparam int EXEC  = 2000;
    localparam int CLEAR = 82000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [31:0] lcd_word;
    logic        wr_ready, busy, lcd_on, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]  lcd_data;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_ctrl u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_valid(wr_valid),
        .i_lcd_word(lcd_word),
        .o_wr_ready(wr_ready),
        .o_busy    (busy),
        .o_lcd_on  (lcd_on),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_rw  (lcd_rw),
        .o_lcd_en  (lcd_en),
        .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one word (DUT must be ready) and time the resulting bus cycle.
    task automatic run_write(input string tag, input logic [31:0] word, input logic exp_rs,
                             input logic [7:0] exp_data, input int exp_total,
                             input bit hold, input logic [31:0] next_word);
        int   rise, fall, rdy, pulses;
        logic prev_en;
        wr_valid = 1'b1;
        lcd_word = word;
        step();
        if (hold) lcd_word = next_word;
        else      wr_valid = 1'b0;
        check({tag, "_data"}, 32'(lcd_data), 32'(exp_data));
        check({tag, "_rs"}, 32'(lcd_rs), 32'(exp_rs));
        check({tag, "_on"}, 32'(lcd_on), 32'd1);
        check({tag, "_ready_low"}, 32'(wr_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        rise = -1; fall = -1; rdy = -1; pulses = 0; prev_en = lcd_en;
        for (int c = 1; c <= exp_total + 20; c++) begin
            step();
            if (lcd_en && !prev_en) begin
                pulses++;
                if (rise < 0) rise = c;
            end
            if (!lcd_en && prev_en && fall < 0) fall = c;
            prev_en = lcd_en;
            if (wr_ready) begin
                rdy = c;
                break;
            end
        end
        check({tag, "_en_rise"}, 32'(rise), 32'(SETUP));
        check({tag, "_en_fall"}, 32'(fall), 32'(SETUP + ENH));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_ready_cyc"}, 32'(rdy), 32'(exp_total));
        check({tag, "_data_kept"}, 32'(lcd_data), 32'(exp_data));
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        lcd_word = 32'h0;
        step();
        step();
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_on", 32'(lcd_on), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_en", 32'(lcd_en), 32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        rst = 1'b0;

`ifdef LCD_INIT_SEQ_EN
        begin
            logic [7:0] seen [4];
            int         pulses, rdy;
            logic       prev_en;
            pulses = 0; rdy = -1; prev_en = 1'b0;
            for (int c = 1; c <= 90000; c++) begin
                step();
                if (lcd_en && !prev_en) begin
                    if (pulses < 4) seen[pulses] = lcd_data;
                    pulses++;
                    check("init_on", 32'(lcd_on), 32'd1);
                    check("init_rs", 32'(lcd_rs), 32'd0);
                end
                prev_en = lcd_en;
                if (wr_ready) begin
                    rdy = c;
                    break;
                end
            end
            check("init_pulses", 32'(pulses), 32'd4);
            check("init_d0", 32'(seen[0]), 32'h38);
            check("init_d1", 32'(seen[1]), 32'h0C);
            check("init_d2", 32'(seen[2]), 32'h01);
            check("init_d3", 32'(seen[3]), 32'h06);
            check("init_ready_cyc", 32'(rdy), 32'(4 * (1 + SETUP + ENH + HOLD) + 3 * EXEC + CLEAR));
        end
`else
        step();
        check("release_ready", 32'(wr_ready), 32'd1);

        // 'A' with a second word held on the bus while busy.
        run_write("char_a", 32'h8000_0441, 1'b1, 8'h41, SETUP + ENH + HOLD + EXEC,
                  1'b1, 32'h8000_0442);
        run_write("char_b", 32'h8000_0442, 1'b1, 8'h42, SETUP + ENH + HOLD + EXEC,
                  1'b0, 32'h0);
        repeat (3) step();
        check("once_ready", 32'(wr_ready), 32'd1);
        check("once_busy", 32'(busy), 32'd0);

        run_write("clear", 32'h8000_0001, 1'b0, 8'h01, SETUP + ENH + HOLD + CLEAR,
                  1'b0, 32'h0);
`endif

        // Off-only word: single cycle, no bus activity.
        wr_valid = 1'b1;
        lcd_word = 32'h0000_0000;
        step();
        wr_valid = 1'b0;
        check("off_on", 32'(lcd_on), 32'd0);
        check("off_ready", 32'(wr_ready), 32'd1);
        check("off_busy", 32'(busy), 32'd0);
        check("off_en", 32'(lcd_en), 32'd0);
        step();
        check("off_ready2", 32'(wr_ready), 32'd1);

`ifndef LCD_INIT_SEQ_EN
        // Reset in the middle of the EN pulse.
        wr_valid = 1'b1;
        lcd_word = 32'h8000_0441;
        step();
        wr_valid = 1'b0;
        repeat (SETUP + 2) step();
        check("mid_en_high", 32'(lcd_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en", 32'(lcd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(lcd_data), 32'd0);
        check("mid_rst_on", 32'(lcd_on), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("mid_rel_ready", 32'(wr_ready), 32'd1);
        check("mid_rel_busy", 32'(busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
